// File: rtl/memshare_shift_gen_pkg.sv
// Shared types and sizing for the memShare scheduler stages.
// Also holds the shift-width helper, which the mod-Z adder uses as well.
package memShare_sched_pkg;

   localparam int Z_DEF = 85;

   function automatic int shift_width(input int z);
      return (z > 1) ? $clog2(z) : 1;
   endfunction

   localparam int SHIFT_W_DEF = shift_width(Z_DEF);

   typedef enum logic [1:0] {
      IDLE          = 2'd0,
      READ_COL_ADDR = 2'd1,
      SHIFT_GEN     = 2'd2,
      DONE          = 2'd3
   } shiftGen_state_e;

endpackage

// File: rtl/memshare_shift_gen_mod_add.sv
// Combinational modulo-Z adder for two operands already in [0, Z-1].
// A single conditional subtract is enough because the sum never reaches 2Z.
module memShare_mod_add
   import memShare_sched_pkg::*;
#(
   parameter int Z       = Z_DEF,
   parameter int SHIFT_W = shift_width(Z)
) (
   input  logic [SHIFT_W-1:0] i_a,
   input  logic [SHIFT_W-1:0] i_b,
   output logic [SHIFT_W-1:0] o_shift,
   output logic               o_gtr
);

   logic [SHIFT_W:0] w_sum;

   assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
   assign o_gtr   = (w_sum >= (SHIFT_W+1)'(Z));
   assign o_shift = o_gtr ? SHIFT_W'(w_sum - (SHIFT_W+1)'(Z)) : SHIFT_W'(w_sum);

endmodule

// File: rtl/memshare_shift_gen.sv
// SHIFT_GEN stage: accumulates column circulant shifts modulo Z per memShare
// operation and reports the wrapped shift, wrap flag and running wrap parity.
//
// state         | meaning
// IDLE          | waiting for start_i; delta FF held clear
// READ_COL_ADDR | accepting the next column shift
// SHIFT_GEN     | result presented, waiting for out_ready_i
// DONE          | one-cycle done_o pulse after the last result
module memshare_shift_gen
   import memShare_sched_pkg::*;
#(
   parameter int Z         = Z_DEF,
   parameter int SHIFT_W   = shift_width(Z),
   parameter int REQ_NUM   = 4,
   parameter int REQ_CNT_W = $clog2(REQ_NUM) + 1
) (
   input  logic               sys_clk,
   input  logic               rstn,
   input  logic               start_i,
   input  logic [SHIFT_W-1:0] base_shift_i,
   input  logic               flush_i,
   input  logic               col_valid_i,
   input  logic [SHIFT_W-1:0] col_shift_i,
   output logic               col_ready_o,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [SHIFT_W-1:0] shift_o,
   output logic               isGtr_o,
   output logic               delta_o,
   output logic               busy_o,
   output logic               done_o
);

   shiftGen_state_e        r_state;
   logic [SHIFT_W-1:0]     r_acc;
   logic [SHIFT_W-1:0]     r_col;
   logic [REQ_CNT_W-1:0]   r_cnt;
   logic                   r_delta;

   logic [SHIFT_W-1:0]     w_shift;
   logic                   w_gtr;

   memShare_mod_add #(
      .Z       (Z),
      .SHIFT_W (SHIFT_W)
   ) u_mod_add (
      .i_a     (r_col),
      .i_b     (r_acc),
      .o_shift (w_shift),
      .o_gtr   (w_gtr)
   );

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_col   <= '0;
         r_cnt   <= '0;
         r_delta <= 1'b0;
      end else if (flush_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_delta <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_delta <= 1'b0;
               if (start_i) begin
                  r_acc   <= base_shift_i;
                  r_cnt   <= '0;
                  r_state <= READ_COL_ADDR;
               end
            end
            READ_COL_ADDR: begin
               if (col_valid_i) begin
                  r_col   <= col_shift_i;
                  r_state <= SHIFT_GEN;
               end
            end
            SHIFT_GEN: begin
               if (out_ready_i) begin
                  r_acc   <= w_shift;
                  r_delta <= r_delta ^ w_gtr;
                  r_cnt   <= r_cnt + REQ_CNT_W'(1);
                  r_state <= (r_cnt == REQ_CNT_W'(REQ_NUM - 1)) ? DONE : READ_COL_ADDR;
               end
            end
            DONE: begin
               r_delta <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Result fields are forced to zero outside SHIFT_GEN so idle outputs never
   // expose stale accumulator contents.
   assign busy_o      = (r_state != IDLE);
   assign col_ready_o = (r_state == READ_COL_ADDR);
   assign out_valid_o = (r_state == SHIFT_GEN);
   assign done_o      = (r_state == DONE);
   assign shift_o     = out_valid_o ? w_shift : '0;
   assign isGtr_o     = out_valid_o & w_gtr;
   assign delta_o     = out_valid_o & (r_delta ^ w_gtr);

endmodule

// File: tb/tb_memshare_shift_gen.sv
// Randomized bench for memshare_shift_gen against a transaction-level model
// of modulo-Z accumulation and wrap parity.
module tb_memshare_shift_gen;

   localparam int Z   = 85;
   localparam int SW  = 7;
   localparam int RQN = 4;

   logic          sys_clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start_i = 1'b0;
   logic [SW-1:0] base_shift_i = '0;
   logic          flush_i = 1'b0;
   logic          col_valid_i = 1'b0;
   logic [SW-1:0] col_shift_i = '0;
   logic          col_ready_o;
   logic          out_valid_o;
   logic          out_ready_i = 1'b0;
   logic [SW-1:0] shift_o;
   logic          isGtr_o;
   logic          delta_o;
   logic          busy_o;
   logic          done_o;

   memshare_shift_gen #(
      .Z         (Z),
      .SHIFT_W   (SW),
      .REQ_NUM   (RQN),
      .REQ_CNT_W (3)
   ) dut (
      .sys_clk      (sys_clk),
      .rstn         (rstn),
      .start_i      (start_i),
      .base_shift_i (base_shift_i),
      .flush_i      (flush_i),
      .col_valid_i  (col_valid_i),
      .col_shift_i  (col_shift_i),
      .col_ready_o  (col_ready_o),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .shift_o      (shift_o),
      .isGtr_o      (isGtr_o),
      .delta_o      (delta_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 sys_clk = ~sys_clk;

   int n_pass = 0;
   int n_total = 0;
   int e_shift[$];
   int e_gtr[$];
   int e_delta[$];
   int out_idx = 0;
   int n_done = 0;
   int exp_done = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Expected results of one operation: running sum modulo Z, wrap flag,
   // and parity of the wraps seen so far.
   task automatic model_op(input int base, input int cols[4]);
      int acc;
      int d;
      e_shift.delete(); e_gtr.delete(); e_delta.delete();
      out_idx = 0;
      acc = base;
      d = 0;
      for (int i = 0; i < RQN; i++) begin
         int s;
         int g;
         s = acc + cols[i];
         g = (s >= Z) ? 1 : 0;
         acc = s % Z;
         d = d ^ g;
         e_shift.push_back(acc);
         e_gtr.push_back(g);
         e_delta.push_back(d);
      end
   endtask

   always @(negedge sys_clk) begin
      if (rstn) begin
         if (col_valid_i)
            assert (col_shift_i < Z) else $error("column shift out of range");
         if (done_o) n_done++;
         if (out_valid_o) begin
            if (out_idx < e_shift.size()) begin
               chk("shift", int'(shift_o), e_shift[out_idx]);
               chk("isGtr", int'(isGtr_o), e_gtr[out_idx]);
               chk("delta", int'(delta_o), e_delta[out_idx]);
               chk("sg_col_ready", int'(col_ready_o), 0);
               chk("sg_busy", int'(busy_o), 1);
            end else begin
               chk("unexpected_result", out_idx, e_shift.size() - 1);
            end
            if (out_ready_i) out_idx++;
         end
      end
   end

   task automatic run_op(input int base, input int c0, input int c1, input int c2,
                         input int c3, input int n_res, input int stall,
                         input bit rca_start);
      int cols[4];
      int wc;
      cols = '{c0, c1, c2, c3};
      model_op(base, cols);
      @(posedge sys_clk); #1;
      start_i = 1'b1;
      base_shift_i = SW'(base);
      @(posedge sys_clk); #1;
      start_i = 1'b0;
      base_shift_i = SW'($urandom_range(0, Z - 1));
      for (int i = 0; i < n_res; i++) begin
         repeat (1 + $urandom_range(0, 2)) begin
            @(posedge sys_clk); #1;
         end
         if (rca_start && i == 1) begin
            start_i = 1'b1;
            base_shift_i = SW'($urandom_range(0, Z - 1));
            @(posedge sys_clk); #1;
            start_i = 1'b0;
         end
         col_valid_i = 1'b1;
         col_shift_i = SW'(cols[i]);
         wc = 0;
         @(negedge sys_clk);
         while (!col_ready_o && wc < 20) begin
            @(posedge sys_clk); #1;
            wc++;
            @(negedge sys_clk);
         end
         if (!col_ready_o) begin
            chk("col_ready_timeout", 0, 1);
            col_valid_i = 1'b0;
            return;
         end
         @(posedge sys_clk); #1;
         col_valid_i = 1'b0;
         col_shift_i = SW'($urandom_range(0, Z - 1));
         out_ready_i = (stall == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge sys_clk);
         chk("col_to_out_latency", int'(out_valid_o), 1);
         wc = 0;
         while (!(out_valid_o && out_ready_i) && wc < 40) begin
            @(posedge sys_clk); #1;
            wc++;
            out_ready_i = (wc < stall) ? 1'b0 :
                          (wc > stall + 4) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge sys_clk);
         end
         if (!(out_valid_o && out_ready_i)) begin
            chk("out_hs_timeout", 0, 1);
            out_ready_i = 1'b0;
            return;
         end
         @(posedge sys_clk); #1;
         out_ready_i = 1'b0;
         @(negedge sys_clk);
         if (i == RQN - 1) begin
            exp_done++;
            chk("done_pulse", int'(done_o), 1);
            chk("done_busy", int'(busy_o), 1);
            @(posedge sys_clk); #1;
            @(negedge sys_clk);
            chk("done_one_cycle", int'(done_o), 0);
            chk("idle_busy", int'(busy_o), 0);
            chk("results_seen", out_idx, RQN);
         end else begin
            chk("back_to_rca", int'(col_ready_o), 1);
            chk("no_early_done", int'(done_o), 0);
         end
      end
   endtask

   initial begin
      #23;
      @(negedge sys_clk);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_valid", int'(out_valid_o), 0);
      chk("rst_col_ready", int'(col_ready_o), 0);
      chk("rst_shift", int'(shift_o), 0);
      chk("rst_done", int'(done_o), 0);
      rstn = 1'b1;

      run_op(10, 20, 60, 0, 84, RQN, 0, 1'b0);
      chk("pin_shift0", e_shift[0], 30);
      chk("pin_shift1", e_shift[1], 5);
      chk("pin_gtr1", e_gtr[1], 1);
      chk("pin_shift3", e_shift[3], 4);
      chk("pin_delta3", e_delta[3], 0);

      run_op(40, 45, 44, 84, 1, RQN, 0, 1'b0);
      chk("pin_bound_eq", e_shift[0], 0);
      chk("pin_bound_eq_gtr", e_gtr[0], 1);
      run_op(40, 44, 0, 84, 84, RQN, 0, 1'b0);
      chk("pin_bound_lt", e_shift[0], 84);
      chk("pin_bound_lt_gtr", e_gtr[0], 0);

      run_op(7, 50, 33, 78, 2, RQN, 5, 1'b0);
      run_op(12, 3, 4, 5, 6, RQN, 0, 1'b1);

      run_op(10, 20, 60, 0, 84, 2, 0, 1'b0);
      chk("pin_flush_delta", e_delta[1], 1);
      @(posedge sys_clk); #1;
      flush_i = 1'b1;
      start_i = 1'b1;
      col_valid_i = 1'b1;
      col_shift_i = SW'(5);
      @(posedge sys_clk); #1;
      flush_i = 1'b0;
      start_i = 1'b0;
      col_valid_i = 1'b0;
      @(negedge sys_clk);
      chk("flush_busy", int'(busy_o), 0);
      chk("flush_col_ready", int'(col_ready_o), 0);
      chk("flush_valid", int'(out_valid_o), 0);
      chk("flush_done", int'(done_o), 0);
      run_op(0, 84, 84, 1, 0, RQN, 1, 1'b0);

      run_op(20, 30, 0, 0, 0, 0, 0, 1'b0);
      @(posedge sys_clk); #1;
      col_valid_i = 1'b1;
      col_shift_i = SW'(30);
      @(posedge sys_clk); #1;
      col_valid_i = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_valid", int'(out_valid_o), 0);
      chk("arst_busy", int'(busy_o), 0);
      chk("arst_shift", int'(shift_o), 0);
      chk("arst_gtr", int'(isGtr_o), 0);
      chk("arst_delta", int'(delta_o), 0);
      chk("arst_col_ready", int'(col_ready_o), 0);
      #3;
      rstn = 1'b1;
      repeat (3) begin
         @(negedge sys_clk);
         chk("post_rst_idle", int'(busy_o), 0);
      end

      for (int k = 0; k < 30; k++) begin
         run_op($urandom_range(0, Z - 1), $urandom_range(0, Z - 1),
                $urandom_range(0, Z - 1), $urandom_range(0, Z - 1),
                $urandom_range(0, Z - 1), RQN, $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
      end

      repeat (2) @(negedge sys_clk);
      chk("done_count", n_done, exp_done);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
